// File: rtl/carry_resolve_78_pkg.sv
// Shared widths and FSM encoding for the 78-bit-radix carry resolver.
// The inner loop and the outer-loop controller import the same constants.
package carry_resolve_78_pkg;

    localparam int SIZE   = 3072;
    localparam int RADIX  = 78;
    localparam int SW     = SIZE + RADIX + 2;
    localparam int NCH    = (SW + RADIX - 1) / RADIX;
    localparam int LAST_W = SW - (NCH - 1) * RADIX;
    // Operand shift registers are padded to whole chunks so the last chunk arrives zero-extended
    localparam int PAD_W  = NCH * RADIX;
    localparam int IDX_W  = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carry_resolve_78_if.sv
// Load/result bundle between the inner loop and the carry resolver.
interface carry_resolve_78_if;
    import carry_resolve_78_pkg::*;

    logic          en;
    logic [SW-1:0] r0;
    logic [SW-1:0] r1;
    logic          busy;
    logic          done;
    logic [SW-1:0] sum;
    logic          cout;

    modport master (output en, r0, r1, input busy, done, sum, cout);
    modport slave  (input en, r0, r1, output busy, done, sum, cout);

endinterface

// File: rtl/carry_resolve_78_chunk_add.sv
// One radix-wide ripple stage of the chunk-serial adder.
module chunk_add_78 #(
    parameter int W = 78
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/carry_resolve_78.sv
// Resolves the redundant r0/r1 pair into a binary sum, one 78-bit chunk per cycle.
// Operands shift right so the adder always sees the current LSB chunk.
module carry_resolve_78
    import carry_resolve_78_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    carry_resolve_78_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_en_prev;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic [PAD_W-1:0]   r_opa;
    logic [PAD_W-1:0]   r_opb;
    logic [SW-1:0]      w_sum;
    logic [RADIX-1:0]   w_chunk_sum;
    logic               w_chunk_cout;
    logic               w_load;
    logic               w_start;
    logic               w_last;
    logic               w_busy;
    logic               w_done;

    // A held en level only loads once; DONE accepts it again for back-to-back resolves
    assign w_load  = bus.en && (!r_en_prev || (r_state == ST_DONE));
    assign w_start = w_load && (r_state != ST_ADD);
    assign w_last  = (r_idx == IDX_W'(NCH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_ADD;
            ST_ADD:  if (w_last)  w_state_next = ST_DONE;
            ST_DONE: w_state_next = w_load ? ST_ADD : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_ADD:  w_busy = 1'b1;
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    chunk_add_78 #(.W(RADIX)) u_chunk_add (
        .i_a    (r_opa[RADIX-1:0]),
        .i_b    (r_opb[RADIX-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_prev <= 1'b0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
        end else begin
            r_en_prev <= bus.en;
            if (w_start) begin
                r_opa   <= PAD_W'(bus.r0);
                r_opb   <= PAD_W'(bus.r1);
                r_idx   <= '0;
                r_carry <= 1'b0;
                r_cout  <= 1'b0;
            end else if (r_state == ST_ADD) begin
                r_opa   <= r_opa >> RADIX;
                r_opb   <= r_opb >> RADIX;
                r_idx   <= r_idx + 1'b1;
                r_carry <= w_chunk_cout;
                // Last chunk is zero-extended, so bit LAST_W is the carry out of the full add
                if (w_last) begin
                    r_cout <= w_chunk_sum[LAST_W];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_sum_chunk
            localparam int CW = (gi == NCH - 1) ? LAST_W : RADIX;
            logic [CW-1:0] r_chunk;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_chunk <= '0;
                end else if ((r_state == ST_ADD) && (r_idx == IDX_W'(gi))) begin
                    r_chunk <= w_chunk_sum[CW-1:0];
                end
            end

            assign w_sum[gi*RADIX +: CW] = r_chunk;
        end
    endgenerate

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = w_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_carry_resolve_78.sv
// Directed-vector and random back-to-back bench for carry_resolve_78.
module tb_carry_resolve_78;
    localparam int SW = carry_resolve_78_pkg::SW;

    typedef struct {
        string         name;
        logic [SW-1:0] r0;
        logic [SW-1:0] r1;
        logic [SW-1:0] sum;
        logic          cout;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    carry_resolve_78_if bus ();

    carry_resolve_78 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bits(input string name, input logic [SW:0] act, input logic [SW:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got lo=%h hi=%h, expected lo=%h hi=%h",
                     name, act[63:0], act[SW:SW-63], exp[63:0], exp[SW:SW-63]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [SW-1:0] rnd();
        logic [SW-1:0] t;
        for (int k = 0; k < 98; k++) t[k*32 +: 32] = $urandom;
        t[SW-1:SW-16] = 16'($urandom);
        return t;
    endfunction

    // Pulse-load one pair and watch 60 cycles from the cycle after the load edge
    task automatic run_single(input logic [SW-1:0] a, input logic [SW-1:0] b,
                              output logic [SW-1:0] s, output logic c,
                              output int lat, output int busy_n, output int done_n);
        @(negedge clk);
        bus.r0 = a; bus.r1 = b; bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        lat = -1; busy_n = 0; done_n = 0; s = '0; c = 1'b0;
        for (int cy = 0; cy < 60; cy++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (lat < 0) begin lat = cy; s = bus.sum; c = bus.cout; end
            end
            @(negedge clk);
        end
    endtask

    vec_t          vecs[8];
    logic [SW-1:0] ones, one, s, a, b;
    logic [SW:0]   model;
    logic          c;
    int            lat, busy_n, done_n, found;

    initial begin
        n_pass = 0; n_total = 0;
        ones = '1; one = SW'(1);
        vecs[0] = '{"ripple",      one,           ones,     '0,                   1'b1};
        vecs[1] = '{"zero",        '0,            '0,       '0,                   1'b0};
        vecs[2] = '{"lastw_bound", one << 3119,   one << 3119, one << 3120,       1'b0};
        vecs[3] = '{"msb_wrap",    one << 3151,   one << 3151, '0,                1'b1};
        vecs[4] = '{"small",       SW'(5),        SW'(7),   SW'(12),              1'b0};
        vecs[5] = '{"chunk0_cross",(one << 78) - one, one,  one << 78,            1'b0};
        vecs[6] = '{"all_ones",    ones,          ones,     ones - one,           1'b1};
        vecs[7] = '{"to_last",     (one << 3120) - one, one, one << 3120,         1'b0};

        rst = 1'b1; bus.en = 1'b0; bus.r0 = '0; bus.r1 = '0;
        repeat (3) @(negedge clk);
        check_int("rst_busy", int'(bus.busy), 0);
        check_int("rst_done", int'(bus.done), 0);
        check_bits("rst_sum", {1'b0, bus.sum}, '0);
        check_int("rst_cout", int'(bus.cout), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i].r0, vecs[i].r1, s, c, lat, busy_n, done_n);
            check_bits({vecs[i].name, "_sum"}, {c, s}, {vecs[i].cout, vecs[i].sum});
            check_int({vecs[i].name, "_lat"}, lat, 41);
            check_int({vecs[i].name, "_busy"}, busy_n, 41);
            check_int({vecs[i].name, "_dones"}, done_n, 1);
            $display("vec %s: lat=%0d busy=%0d dones=%0d cout=%0d", vecs[i].name, lat, busy_n, done_n, c);
        end

        // Held en for 5 cycles, then a mid-ADD pulse with other operands: one result only
        a = SW'(3); b = one << 200;
        @(negedge clk);
        bus.r0 = a; bus.r1 = b; bus.en = 1'b1;
        @(negedge clk);
        done_n = 0; s = '0;
        for (int cy = 0; cy < 80; cy++) begin
            if (bus.done) begin done_n++; s = bus.sum; end
            bus.en = (cy < 4) || (cy == 20);
            bus.r0 = (cy == 20) ? one : a;
            bus.r1 = (cy == 20) ? one : b;
            @(negedge clk);
        end
        bus.en = 1'b0;
        check_int("held_dones", done_n, 1);
        check_bits("held_sum", {1'b0, s}, {1'b0, (one << 200) + SW'(3)});
        $display("held: dones=%0d", done_n);

        // Reset while chunk 20 is being added
        @(negedge clk);
        bus.r0 = ones; bus.r1 = '0; bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_int("midrst_busy", int'(bus.busy), 0);
        check_int("midrst_done", int'(bus.done), 0);
        check_bits("midrst_sum", {1'b0, bus.sum}, '0);
        check_int("midrst_cout", int'(bus.cout), 0);
        done_n = 0;
        for (int cy = 0; cy < 60; cy++) begin
            if (bus.done) done_n++;
            @(negedge clk);
        end
        check_int("midrst_nodone", done_n, 0);
        run_single(SW'(5), SW'(7), s, c, lat, busy_n, done_n);
        check_bits("after_rst_sum", {c, s}, {1'b0, SW'(12)});
        $display("midrst: recovery lat=%0d", lat);

        // rst and en together: nothing captured
        @(negedge clk);
        rst = 1'b1; bus.en = 1'b1; bus.r0 = one; bus.r1 = one;
        @(negedge clk);
        rst = 1'b0; bus.en = 1'b0;
        check_int("rst_en_busy", int'(bus.busy), 0);
        done_n = 0;
        for (int cy = 0; cy < 60; cy++) begin
            if (bus.done) done_n++;
            @(negedge clk);
        end
        check_int("rst_en_nodone", done_n, 0);
        $display("rst+en: dones=%0d", done_n);

        // Random back-to-back: en held high, new operands presented in each done cycle
        a = rnd(); b = rnd();
        @(negedge clk);
        bus.r0 = a; bus.r1 = b; bus.en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            model = {1'b0, a} + {1'b0, b};
            found = 0;
            for (int cy = 0; cy < 60 && found == 0; cy++) begin
                @(negedge clk);
                if (bus.done) found = 1;
            end
            if (found == 0) begin
                n_total++;
                $display("FAIL rand_timeout: got no done, expected done within 60 cycles (pair %0d)", i);
                break;
            end
            check_bits("rand_sum", {bus.cout, bus.sum}, model);
            if (i % 100 == 0) $display("rand %0d: cout=%0d lo=%h", i, bus.cout, bus.sum[63:0]);
            if (i < 999) begin
                a = rnd();
                case (i % 4)
                    0:       b = ~a;
                    1:       b = ~a + one;
                    default: b = rnd();
                endcase
                bus.r0 = a; bus.r1 = b;
            end else begin
                bus.en = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
